imm_decode_stage: RTL and testbench

//  Registered decode/immediate stage between fetch and execute of the RV32IM core.

---
 rtl/imm_decode_stage.sv | 152 +++++++++++++++
 tb/tb_imm_decode_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// Decode/immediate stage between fetch and execute: classifies the opcode, builds the
// sign-extended immediate and holds results in a 2-entry skid buffer (or 1 entry when SKID_EN=0).
module imm_decode_stage #(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ins,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    function automatic entry_t decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
        entry_t             e;
        logic [2:0]         fmt;
        logic signed [31:0] imm;
        fmt = FMT_ILL;
        if (ins[1:0] == 2'b11) begin
            case (ins[6:0])
                7'b0110111, 7'b0010111:                         fmt = FMT_U;
                7'b1101111:                                     fmt = FMT_J;
                7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: fmt = FMT_I;
                7'b0100011:                                     fmt = FMT_S;
                7'b1100011:                                     fmt = FMT_B;
                7'b0110011:                                     fmt = FMT_R;
                default:                                        fmt = FMT_ILL;
            endcase
        end
        case (fmt)
            FMT_I:   imm = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   imm = {ins[31:12], 12'h000};
            FMT_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        e.opcode  = ins[6:0];
        e.rd      = (fmt == FMT_S || fmt == FMT_B || fmt == FMT_ILL) ? 5'd0 : ins[11:7];
        e.imm     = imm;
        e.fmt     = fmt;
        e.illegal = (fmt == FMT_ILL);
        e.pc      = pc;
        return e;
    endfunction

    state_t state_p1, state_d;
    entry_t main_p1, skid_p1, dec_p0;
    logic   vld_p1;
    logic   push, pop;
    logic   load_main, load_skid, skid_to_main;

    assign dec_p0 = decode(in_ins, in_pc);

    // The skid variant's ready depends only on the state register; rst_n gating keeps it low in reset.
    assign in_ready = SKID_EN ? (rst_n && state_p1 != FULL)
                              : (rst_n && (out_ready || !vld_p1));
    assign push     = in_valid && in_ready;
    assign pop      = vld_p1 && out_ready;

    always_comb begin
        state_d      = state_p1;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state_p1)
            EMPTY: begin
                if (push) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_main = 1'b1;
                end else if (push && SKID_EN) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d      = ONE;
                    skid_to_main = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d      = EMPTY;
            load_main    = 1'b0;
            load_skid    = 1'b0;
            skid_to_main = 1'b0;
        end
    end

    // Stage boundary: decoded entries captured into main/skid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= EMPTY;
            vld_p1   <= 1'b0;
            main_p1  <= '0;
            skid_p1  <= '0;
        end else begin
            state_p1 <= state_d;
            vld_p1   <= (state_d != EMPTY);
            if (load_main)         main_p1 <= dec_p0;
            else if (skid_to_main) main_p1 <= skid_p1;
            if (load_skid)         skid_p1 <= dec_p0;
        end
    end

    assign out_valid   = vld_p1;
    assign out_opcode  = main_p1.opcode;
    assign out_rd      = main_p1.rd;
    assign out_imm     = main_p1.imm;
    assign out_fmt     = main_p1.fmt;
    assign out_illegal = main_p1.illegal;
    assign out_pc      = main_p1.pc;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: decode vectors, backpressure, streaming, flush and reset.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_ins, in_pc, out_imm, out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_fmt;

    int n_checks = 0;
    int n_errors = 0;

    imm_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_illegal(out_illegal), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Push one instruction into an empty stage with out_ready=1 and check the decoded entry.
    task automatic xfer1(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] e_imm, input logic [2:0] e_fmt, input logic [4:0] e_rd);
        in_valid  = 1'b1;
        in_ins    = ins;
        in_pc     = pc;
        out_ready = 1'b1;
        check({tag, ".rdy"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        check({tag, ".vld"}, out_valid, 1);
        check({tag, ".imm"}, out_imm, e_imm);
        check({tag, ".fmt"}, out_fmt, e_fmt);
        check({tag, ".rd"}, out_rd, e_rd);
        check({tag, ".ill"}, out_illegal, e_fmt == 3'd7);
        check({tag, ".opc"}, out_opcode, ins[6:0]);
        check({tag, ".pc"}, out_pc, pc);
        step();
        check({tag, ".drain"}, out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ins = '0; in_pc = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst.vld", out_valid, 0);
        check("rst.rdy", in_ready, 0);
        check("rst.imm", out_imm, 0);
        check("rst.pc", out_pc, 0);
        check("rst.fmt", out_fmt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel.rdy", in_ready, 1);

        // T1, T2, T5 and extra decode vectors
        xfer1("lui",   32'h123450B7, 32'h100, 32'h12345000, 3'd4, 5'd1);
        xfer1("beq",   32'hFE000EE3, 32'h104, 32'hFFFFFFFC, 3'd3, 5'd0);
        xfer1("jal",   32'h0040006F, 32'h108, 32'h00000004, 3'd5, 5'd0);
        xfer1("jalm",  32'hFFDFF06F, 32'h10C, 32'hFFFFFFFC, 3'd5, 5'd0);
        xfer1("zero",  32'h00000000, 32'h110, 32'h0,        3'd7, 5'd0);
        xfer1("x7f",   32'h0000007F, 32'h114, 32'h0,        3'd7, 5'd0);
        xfer1("nop",   32'h00000013, 32'h118, 32'h0,        3'd1, 5'd0);
        xfer1("sw",    32'h00112623, 32'h11C, 32'h0000000C, 3'd2, 5'd0);
        xfer1("addim", 32'hFFF00093, 32'h120, 32'hFFFFFFFF, 3'd1, 5'd1);
        xfer1("add",   32'h002081B3, 32'h124, 32'h0,        3'd0, 5'd3);
        xfer1("auipc", 32'hFFFFF517, 32'h128, 32'hFFFFF000, 3'd4, 5'd10);
        xfer1("lo2",   32'hFFF00091, 32'h12C, 32'h0,        3'd7, 5'd0);

        // T3: backpressure, A/B fill the buffer, C held upstream
        out_ready = 1'b0;
        in_valid = 1'b1; in_ins = 32'h00100093; in_pc = 32'h200;
        check("t3.rdyA", in_ready, 1);
        step();
        in_ins = 32'h00200093; in_pc = 32'h204;
        check("t3.rdyB", in_ready, 1);
        step();
        in_ins = 32'h00300093; in_pc = 32'h208;
        check("t3.rdyFull", in_ready, 0);
        step();
        check("t3.rdyHold", in_ready, 0);
        check("t3.pcHold", out_pc, 32'h200);
        check("t3.immHold", out_imm, 32'h1);
        out_ready = 1'b1;
        step();
        check("t3.vldB", out_valid, 1);
        check("t3.pcB", out_pc, 32'h204);
        check("t3.immB", out_imm, 32'h2);
        check("t3.rdyB2", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("t3.vldC", out_valid, 1);
        check("t3.pcC", out_pc, 32'h208);
        check("t3.immC", out_imm, 32'h3);
        step();
        check("t3.empty", out_valid, 0);

        // T4: 16 instructions streamed back-to-back
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) begin
                in_valid = 1'b1;
                in_ins   = (32'(i) << 20) | (32'(i) << 7) | 32'h13;
                in_pc    = 32'h1000 + 32'(4 * i);
                check("t4.rdy", in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            if (i > 0) begin
                check("t4.vld", out_valid, 1);
                check("t4.pc", out_pc, 32'h1000 + 32'(4 * (i - 1)));
                check("t4.imm", out_imm, 32'(i - 1));
            end
            step();
        end
        check("t4.empty", out_valid, 0);

        // T6: flush while FULL with a competing push
        out_ready = 1'b0;
        in_valid = 1'b1; in_ins = 32'h00500093; in_pc = 32'h300;
        step();
        in_pc = 32'h304;
        step();
        check("t6.full", in_ready, 0);
        flush = 1'b1; in_pc = 32'h308;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("t6.vld", out_valid, 0);
        check("t6.rdy", in_ready, 1);
        check("t6.pcKeep", out_pc, 32'h300);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6.quiet", out_valid, 0);
        end

        // Mid-stream asynchronous reset
        out_ready = 1'b0;
        in_valid = 1'b1; in_ins = 32'h123450B7; in_pc = 32'h400;
        step();
        in_valid = 1'b0;
        check("t6.preRst", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst2.vld", out_valid, 0);
        check("rst2.imm", out_imm, 0);
        check("rst2.pc", out_pc, 0);
        check("rst2.rdy", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst2.rdyRel", in_ready, 1);
        check("rst2.vldRel", out_valid, 0);
        @(negedge clk);
        xfer1("post", 32'h0040006F, 32'h500, 32'h00000004, 3'd5, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
